baccarat_ctrl: RTL and testbench

Sequencing controller for the baccarat scoring datapath. It deals cards by pulsing load enables for the player and dealer card registers, and applies the third-card drawing rules using the hand totals computed by the scoring logic. It then declares the winner on two lights. It is a pure controller: card registers and score adders live in the datapath, and this block only consumes their totals.

---
 rtl/baccarat_ctrl.sv | 164 ++++++++++++++++
 tb/tb_baccarat_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/baccarat_ctrl.sv
// Purpose : sequencing FSM for the baccarat datapath; pulses card load enables, applies
//           the third-card rules from the datapath hand totals and drives the win lights.
// Latency : RESULT is entered 6/7/8/9 edges after reset release (natural / dealer-only
//           draw / player-only draw / both draw).
// Backpressure: none; the datapath always captures a card on the edge leaving a DEAL/DRAW state.
//
// Ports:
//   slow_clock        single clock, rising edge
//   resetb            asynchronous active-low reset (forces IDLE, all outputs low)
//   pscore, dscore    player / dealer hand totals (0-9) from the datapath
//   pcard3            player third card rank (1-13) from the datapath register
//   load_pcard1..3    one-cycle load enables for the player card registers
//   load_dcard1..3    one-cycle load enables for the dealer card registers
//   player_win_light  player wins (both lights high means a tie)
//   dealer_win_light  dealer wins
//   round_done        high while in RESULT
//
// Optional build macro: AUTO_RESTART_EN
//   defined   : RESULT lasts RESULT_HOLD cycles, then IDLE and a new round starts.
//   undefined : RESULT is terminal until reset; RESULT_HOLD is ignored.

module baccarat_ctrl #(
  parameter int RESULT_HOLD = 4
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       round_done
);

  // Elaboration-time range guard for the hold count (the counter is 4 bits wide).
  if (RESULT_HOLD < 1 || RESULT_HOLD > 15) begin : g_bad_hold
    $error("baccarat_ctrl: RESULT_HOLD must be in 1..15");
  end

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DEAL_P1   = 4'd1,
    S_DEAL_D1   = 4'd2,
    S_DEAL_P2   = 4'd3,
    S_DEAL_D2   = 4'd4,
    S_EVAL      = 4'd5,
    S_DRAW_P3   = 4'd6,
    S_BANK_EVAL = 4'd7,
    S_DRAW_D3   = 4'd8,
    S_RESULT    = 4'd9
  } state_t;

  state_t state;
  state_t state_nxt;

  // Face cards and tens count as zero.
  logic [3:0] pcard3_val;
  assign pcard3_val = (pcard3 > 4'd9) ? 4'd0 : pcard3;

  // Dealer third-card rule once the player has taken a third card.
  logic dealer_draws;
  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (pcard3_val != 4'd8);
      4'd4:             dealer_draws = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
      4'd5:             dealer_draws = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
      4'd6:             dealer_draws = (pcard3_val == 4'd6) || (pcard3_val == 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

  logic natural;
  assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

`ifdef AUTO_RESTART_EN
  localparam logic [3:0] HOLD_LAST = 4'(RESULT_HOLD - 1);
  logic [3:0] hold_cnt;
  logic       hold_done;
  assign hold_done = (hold_cnt >= HOLD_LAST);
`endif

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:    state_nxt = S_DEAL_P1;
      S_DEAL_P1: state_nxt = S_DEAL_D1;
      S_DEAL_D1: state_nxt = S_DEAL_P2;
      S_DEAL_P2: state_nxt = S_DEAL_D2;
      S_DEAL_D2: state_nxt = S_EVAL;
      S_EVAL: begin
        // Natural wins take priority; otherwise player 0-5 draws, 6-7 stands and
        // the dealer then draws on 0-5.
        if (natural)
          state_nxt = S_RESULT;
        else if (pscore <= 4'd5)
          state_nxt = S_DRAW_P3;
        else if (dscore <= 4'd5)
          state_nxt = S_DRAW_D3;
        else
          state_nxt = S_RESULT;
      end
      S_DRAW_P3:   state_nxt = S_BANK_EVAL;
      S_BANK_EVAL: state_nxt = dealer_draws ? S_DRAW_D3 : S_RESULT;
      S_DRAW_D3:   state_nxt = S_RESULT;
      S_RESULT: begin
`ifdef AUTO_RESTART_EN
        state_nxt = hold_done ? S_IDLE : S_RESULT;
`else
        state_nxt = S_RESULT;
`endif
      end
      default: state_nxt = S_IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // State plus registered Moore outputs; each output is the decode of the state
  // being entered, so it is in lock-step with the state register.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state       <= S_IDLE;
      load_pcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_dcard3 <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      load_pcard1 <= (state_nxt == S_DEAL_P1);
      load_dcard1 <= (state_nxt == S_DEAL_D1);
      load_pcard2 <= (state_nxt == S_DEAL_P2);
      load_dcard2 <= (state_nxt == S_DEAL_D2);
      load_pcard3 <= (state_nxt == S_DRAW_P3);
      load_dcard3 <= (state_nxt == S_DRAW_D3);
      round_done  <= (state_nxt == S_RESULT);
    end
  end

`ifdef AUTO_RESTART_EN
  // Counts cycles spent in RESULT; cleared on the edge that enters RESULT.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)
      hold_cnt <= 4'd0;
    else if ((state_nxt == S_RESULT) && (state != S_RESULT))
      hold_cnt <= 4'd0;
    else if (state == S_RESULT)
      hold_cnt <= hold_cnt + 4'd1;
  end
`endif

  // Lights follow the live scores but only mean anything in RESULT.
  assign player_win_light = (state == S_RESULT) && (pscore >= dscore);
  assign dealer_win_light = (state == S_RESULT) && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_ctrl.sv
module tb_baccarat_ctrl;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd1;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, round_done;

  baccarat_ctrl #(.RESULT_HOLD(4)) dut (
    .slow_clock      (slow_clock),
    .resetb          (resetb),
    .pscore          (pscore),
    .dscore          (dscore),
    .pcard3          (pcard3),
    .load_pcard1     (load_pcard1),
    .load_pcard2     (load_pcard2),
    .load_pcard3     (load_pcard3),
    .load_dcard1     (load_dcard1),
    .load_dcard2     (load_dcard2),
    .load_dcard3     (load_dcard3),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light),
    .round_done      (round_done)
  );

  always #5 slow_clock = ~slow_clock;

  int tests = 0;
  int fails = 0;

  // Output vector layout: {lp1, ld1, lp2, ld2, lp3, ld3, round_done, pwin, dwin}
  localparam logic [8:0] V_P1 = 9'b100000000;
  localparam logic [8:0] V_D1 = 9'b010000000;
  localparam logic [8:0] V_P2 = 9'b001000000;
  localparam logic [8:0] V_D2 = 9'b000100000;
  localparam logic [8:0] V_P3 = 9'b000010000;
  localparam logic [8:0] V_D3 = 9'b000001000;
  localparam logic [8:0] V_RD = 9'b000000100;

  // Highest dealer total at which the dealer still draws, indexed by the player's
  // third-card value (standard punto banco tableau).
  int draw_limit[10] = '{3, 3, 4, 4, 5, 5, 6, 6, 2, 3};

  typedef struct {
    int p, d, c3, fp, fd;
    bit ep, ed, epw, edw;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [8:0] outv();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3,
            load_dcard3, round_done, player_win_light, dealer_win_light};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b want=%b", name, got, exp);
    end
  endtask

  // Runs one full round from reset: p/d/c3 are presented during dealing and
  // evaluation, fp/fd are the final totals shown once RESULT is reached.
  task automatic run_round(input string nm, input int p, input int d, input int c3,
                           input int fp, input int fd, input bit ep, input bit ed,
                           input bit epw, input bit edw);
    logic [8:0] q[$];
    logic [8:0] res;
    bit         shown;
    res = V_RD | {7'd0, epw, edw};
    q = '{9'd0, V_P1, V_D1, V_P2, V_D2, 9'd0};
    if (ep) begin q.push_back(V_P3); q.push_back(9'd0); end
    if (ed) q.push_back(V_D3);
    for (int k = 0; k < 4; k++) q.push_back(res);
`ifdef AUTO_RESTART_EN
    q.push_back(9'd0);
    q.push_back(V_P1);
`endif
    @(negedge slow_clock);
    resetb = 1'b0;
    pscore = 4'(p);
    dscore = 4'(d);
    pcard3 = 4'(c3);
    @(negedge slow_clock);
    check({nm, "_reset"}, outv(), 9'd0);
    resetb = 1'b1;
    #1 check({nm, "_c0"}, outv(), q[0]);
    shown = 1'b0;
    for (int i = 1; i < q.size(); i++) begin
      @(negedge slow_clock);
      if (q[i][2] && !shown) begin
        pscore = 4'(fp);
        dscore = 4'(fd);
        shown  = 1'b1;
      end
      #1 check($sformatf("%s_c%0d", nm, i), outv(), q[i]);
    end
  endtask

  task automatic run_model(input string nm, input int p, input int d, input int c3,
                           input int fp, input int fd);
    bit nat, pd, dd;
    int v;
    nat = (p >= 8) || (d >= 8);
    pd  = !nat && (p <= 5);
    v   = (c3 >= 10) ? 0 : c3;
    if (nat)     dd = 1'b0;
    else if (pd) dd = (d <= draw_limit[v]);
    else         dd = (d <= 5);
    run_round(nm, p, d, c3, fp, fd, pd, dd, fp >= fd, fd >= fp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    //              p   d  c3  fp  fd  ep ed pw dw
    tbl[0]  = '{ 8,  3,  1,  8,  3, 0, 0, 1, 0};  // natural, player wins
    tbl[1]  = '{ 4,  6,  7,  5,  9, 1, 1, 0, 1};  // both draw
    tbl[2]  = '{ 2,  6, 12,  2,  6, 1, 0, 0, 1};  // face card stands dealer
    tbl[3]  = '{ 7,  5,  3,  7,  7, 0, 1, 1, 1};  // player stands, tie
    tbl[4]  = '{ 6,  7,  3,  6,  7, 0, 0, 0, 1};  // both stand
    tbl[5]  = '{ 3,  9,  4,  3,  9, 0, 0, 0, 1};  // dealer natural
    tbl[6]  = '{ 0,  3,  8,  8,  3, 1, 0, 1, 0};  // dealer 3 vs 8 stands
    tbl[7]  = '{ 1,  3,  9,  0,  0, 1, 1, 1, 1};  // dealer 3 vs 9 draws
    tbl[8]  = '{ 5,  7,  6,  1,  7, 1, 0, 0, 1};  // dealer 7 stands
    tbl[9]  = '{12,  3,  5, 12, 15, 0, 0, 0, 1};  // out-of-range scores, unsigned
    tbl[10] = '{ 5,  6,  6,  1,  2, 1, 1, 0, 1};  // dealer 6 vs 6 draws
    tbl[11] = '{ 5,  4,  1,  6,  4, 1, 0, 1, 0};  // dealer 4 vs 1 stands

    for (int i = 0; i < 12; i++)
      run_round($sformatf("tbl%0d", i), tbl[i].p, tbl[i].d, tbl[i].c3, tbl[i].fp,
                tbl[i].fd, tbl[i].ep, tbl[i].ed, tbl[i].epw, tbl[i].edw);

    // Reset asserted mid-cycle during DEAL_D2, then a clean restart.
    @(negedge slow_clock);
    resetb = 1'b0;
    pscore = 4'd8;
    dscore = 4'd3;
    @(negedge slow_clock);
    resetb = 1'b1;
    for (int i = 1; i <= 4; i++) @(negedge slow_clock);
    #1 check("midrst_in_d2", outv(), V_D2);
    #1 resetb = 1'b0;
    #1 check("midrst_async", outv(), 9'd0);
    @(negedge slow_clock);
    check("midrst_held", outv(), 9'd0);
    resetb = 1'b1;
    #1 check("midrst_idle", outv(), 9'd0);
    @(negedge slow_clock);
    #1 check("midrst_p1", outv(), V_P1);
    @(negedge slow_clock);
    #1 check("midrst_d1", outv(), V_D1);

    // Randomized rounds against the tableau model.
    for (int r = 0; r < 40; r++)
      run_model($sformatf("rnd%0d", r), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(1, 13), $urandom_range(0, 9), $urandom_range(0, 9));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
